// File: rtl/mem_regfile_modal.sv
// Register file with per-register access modes (RW, RO, W1C, PULSE).
// It has single-cycle registered reads, per-register read and write strobes,
// and an interrupt line that summarises every W1C register.
module mem_regfile_modal #(
    parameter int Naddr  = 4,
    parameter int Nbytes = 4,
    parameter logic [2**Naddr-1:0][8*Nbytes-1:0] init_reg = '0,
    parameter logic [2**Naddr-1:0][1:0]          reg_mode = '0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [Naddr-1:0]                     addr,
    input  logic [8*Nbytes-1:0]                  wr_data,
    output logic [8*Nbytes-1:0]                  rd_data,
    input  logic                                 en,
    input  logic [Nbytes-1:0]                    we,
    output logic [2**Naddr-1:0][8*Nbytes-1:0]    reg_val,
    output logic [2**Naddr-1:0][8*Nbytes-1:0]    pul_val,
    input  logic [2**Naddr-1:0][8*Nbytes-1:0]    read_val,
    input  logic [2**Naddr-1:0][8*Nbytes-1:0]    set_val,
    output logic [2**Naddr-1:0]                  wr_pul,
    output logic [2**Naddr-1:0]                  rd_pul,
    output logic                                 irq
);

    localparam int Nregs = 2**Naddr;
    localparam int W     = 8*Nbytes;

    typedef enum logic [1:0] {
        MODE_RW    = 2'd0,
        MODE_RO    = 2'd1,
        MODE_W1C   = 2'd2,
        MODE_PULSE = 2'd3
    } mode_e;

    logic             wr_access;
    logic             rd_access;
    logic [W-1:0]     byte_mask;
    logic [W-1:0]     wr_masked;
    logic [Nregs-1:0] wr_sel;
    logic [Nregs-1:0] rd_sel;
    logic             rd_from_fabric;
    logic             w1c_any;

    assign wr_access = en && (|we);
    assign rd_access = en && (we == '0);
    assign wr_masked = wr_data & byte_mask;
    assign wr_sel    = wr_access ? (Nregs'(1) << addr) : '0;
    assign rd_sel    = rd_access ? (Nregs'(1) << addr) : '0;

    // RO and PULSE registers read back from the fabric instead of reg_val
    assign rd_from_fabric = (reg_mode[addr] == MODE_RO) || (reg_mode[addr] == MODE_PULSE);

    // Expand the byte enables into a per-bit mask
    always_comb begin
        byte_mask = '0;
        for (int b = 0; b < Nbytes; b++) begin
            byte_mask[8*b +: 8] = {8{we[b]}};
        end
    end

    // Any set bit in any W1C register feeds the interrupt
    always_comb begin
        w1c_any = 1'b0;
        for (int i = 0; i < Nregs; i++) begin
            if (reg_mode[i] == MODE_W1C) begin
                w1c_any = w1c_any | (|reg_val[i]);
            end
        end
    end

    // Register contents and write pulses, behaviour chosen per register mode
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < Nregs; i++) begin
                reg_val[i] <= (reg_mode[i] == MODE_W1C) ? '0 : init_reg[i];
            end
            pul_val <= '0;
        end else begin
            pul_val <= '0;
            for (int i = 0; i < Nregs; i++) begin
                case (reg_mode[i])
                    MODE_RW: begin
                        if (wr_sel[i]) begin
                            reg_val[i] <= (reg_val[i] & ~byte_mask) | wr_masked;
                        end
                    end
                    MODE_RO: begin
                        reg_val[i] <= reg_val[i];
                    end
                    MODE_W1C: begin
                        reg_val[i] <= (reg_val[i] & ~(wr_sel[i] ? wr_masked : '0)) | set_val[i];
                    end
                    MODE_PULSE: begin
                        if (wr_sel[i]) begin
                            reg_val[i] <= wr_masked;
                            pul_val[i] <= wr_masked;
                        end
                    end
                    default: begin
                        reg_val[i] <= reg_val[i];
                    end
                endcase
            end
        end
    end

    // Registered read data, access strobes and interrupt
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
            wr_pul  <= '0;
            rd_pul  <= '0;
            irq     <= 1'b0;
        end else begin
            wr_pul <= wr_sel;
            rd_pul <= rd_sel;
            irq    <= w1c_any;
            if (rd_access) begin
                rd_data <= rd_from_fabric ? read_val[addr] : reg_val[addr];
            end
        end
    end

endmodule
